// File: rtl/fifo_param.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and a sticky error flag.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module fifo_param #(
    parameter int WORD_SIZE = 10,
    parameter int MEM_SIZE  = 8,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_wr,
    input  logic                 fifo_rd,
    input  logic [WORD_SIZE-1:0] fifo_data_in,
    input  logic [PTR:0]         full_threshold,
    input  logic [PTR:0]         empty_threshold,
    output logic [WORD_SIZE-1:0] fifo_data_out,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR:0]         fifo_count,
    output logic                 error
);

    localparam logic [PTR:0] DEPTH = (PTR+1)'(MEM_SIZE);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [PTR-1:0]       wr_ptr;
    logic [PTR-1:0]       rd_ptr;
    logic                 rd_acc;
    logic                 wr_acc;

    assign fifo_full    = (fifo_count == DEPTH);
    assign fifo_empty   = (fifo_count == '0);
    assign almost_full  = (fifo_count >= full_threshold);
    assign almost_empty = (fifo_count <= empty_threshold);

    // A full FIFO can still take a write when the same edge pops a word.
    assign rd_acc = reset && fifo_rd && !fifo_empty;
    assign wr_acc = reset && fifo_wr && (!fifo_full || rd_acc);

    // NOTE: the storage array has no reset so it maps onto plain RAM; stale words are
    // unreachable because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= fifo_data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            error      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   fifo_count <= fifo_count + (PTR+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if ((fifo_wr && fifo_full && !rd_acc) || (fifo_rd && fifo_empty)) begin
                error <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign fifo_data_out = fifo_empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_data_out <= '0;
        end else if (rd_acc) begin
            fifo_data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed corner cases plus randomized traffic
// compared against a queue-based reference model (honours FIFO_FWFT_EN).
module tb_fifo_param;

    localparam int WORD_SIZE = 10;
    localparam int MEM_SIZE  = 8;
    localparam int PTR       = 3;

    logic                 clk;
    logic                 reset;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [WORD_SIZE-1:0] fifo_data_in;
    logic [PTR:0]         full_threshold;
    logic [PTR:0]         empty_threshold;
    logic [WORD_SIZE-1:0] fifo_data_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [PTR:0]         fifo_count;
    logic                 error;

    fifo_param #(.WORD_SIZE(WORD_SIZE), .MEM_SIZE(MEM_SIZE), .PTR(PTR)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_wr         (fifo_wr),
        .fifo_rd         (fifo_rd),
        .fifo_data_in    (fifo_data_in),
        .full_threshold  (full_threshold),
        .empty_threshold (empty_threshold),
        .fifo_data_out   (fifo_data_out),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .fifo_count      (fifo_count),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, sticky error, registered output word.
    logic [WORD_SIZE-1:0] model_q[$];
    logic                 model_err;
    logic [WORD_SIZE-1:0] model_dout;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_SIZE-1:0] expected_dout();
`ifdef FIFO_FWFT_EN
        return (model_q.size() > 0) ? model_q[0] : '0;
`else
        return model_dout;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        int n = model_q.size();
        check({tag, "_count"}, 32'(fifo_count),   n);
        check({tag, "_full"},  32'(fifo_full),    32'(n == MEM_SIZE));
        check({tag, "_empty"}, 32'(fifo_empty),   32'(n == 0));
        check({tag, "_afull"}, 32'(almost_full),  32'(n >= int'(full_threshold)));
        check({tag, "_aempty"},32'(almost_empty), 32'(n <= int'(empty_threshold)));
        check({tag, "_error"}, 32'(error),        32'(model_err));
        check({tag, "_dout"},  32'(fifo_data_out),32'(expected_dout()));
    endtask

    // One clock of traffic: called just after a falling edge, returns at the next one.
    task automatic cycle(input logic wr, input logic rd, input logic [WORD_SIZE-1:0] din,
                         input string tag);
        int  n     = model_q.size();
        bit  rd_ok = rd && (n > 0);
        bit  wr_ok = wr && ((n < MEM_SIZE) || rd_ok);
        fifo_wr      = wr;
        fifo_rd      = rd;
        fifo_data_in = din;
        if ((wr && n == MEM_SIZE && !rd_ok) || (rd && n == 0)) model_err = 1'b1;
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then holds it over an
    // edge with live requests that must be ignored.
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_q.delete();
        model_err  = 1'b0;
        model_dout = '0;
        #1;
        check_outputs("rst_async");
        fifo_wr      = 1'b1;
        fifo_rd      = 1'b1;
        fifo_data_in = WORD_SIZE'($urandom);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        reset   = 1'b1;
    endtask

    initial begin
        reset           = 1'b0;
        fifo_wr         = 1'b0;
        fifo_rd         = 1'b0;
        fifo_data_in    = '0;
        full_threshold  = 4'd6;
        empty_threshold = 4'd1;
        model_err       = 1'b0;
        model_dout      = '0;
        @(negedge clk);
        apply_reset();

        // Fill with 1..8; almost_full rises on the 6th write.
        for (int i = 1; i <= MEM_SIZE; i++) begin
            cycle(1'b1, 1'b0, WORD_SIZE'(i), "fill");
`ifdef FIFO_FWFT_EN
            if (i == 1) check("fwft_first", 32'(fifo_data_out), 32'h001);
`endif
            check("fill_afull", 32'(almost_full), 32'(i >= 6));
        end
        check("fill_full",  32'(fifo_full),  1);
        check("fill_count", 32'(fifo_count), 8);
        check("fill_error", 32'(error),      0);

        // Overflow: rejected write, error latches, order preserved.
        cycle(1'b1, 1'b0, 10'h3FF, "ovf");
        check("ovf_error", 32'(error), 1);
        for (int i = 1; i <= MEM_SIZE; i++) begin
`ifdef FIFO_FWFT_EN
            check("drain_head", 32'(fifo_data_out), i);
`endif
            cycle(1'b0, 1'b1, '0, "drain");
`ifndef FIFO_FWFT_EN
            check("drain_word", 32'(fifo_data_out), i);
`endif
        end

        // Underflow on the empty FIFO; error stays set through idle cycles.
        cycle(1'b0, 1'b1, '0, "udf");
        check("udf_error", 32'(error), 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, "udf_idle");

        // Simultaneous read/write on a full FIFO across pointer wrap.
        apply_reset();
        for (int i = 1; i <= MEM_SIZE; i++) cycle(1'b1, 1'b0, WORD_SIZE'(i), "refill");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, WORD_SIZE'(9 + i), "wrap");
        check("wrap_count", 32'(fifo_count), 8);
        check("wrap_error", 32'(error),      0);

        // almost_empty with threshold 1, then reset in the middle of traffic.
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, WORD_SIZE'(10'h50 + i), "ae_fill");
        cycle(1'b0, 1'b1, '0, "ae_rd1");
        check("ae_at2", 32'(almost_empty), 0);
        cycle(1'b0, 1'b1, '0, "ae_rd2");
        check("ae_at1", 32'(almost_empty), 1);
        cycle(1'b1, 1'b0, 10'h77, "pre_rst");
        apply_reset();
        cycle(1'b1, 1'b0, 10'h123, "post_rst");

        // Randomized traffic with shifting bias and thresholds.
        for (int blk = 0; blk < 24; blk++) begin
            int mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) apply_reset();
            full_threshold  = (PTR+1)'($urandom_range(0, 15));
            empty_threshold = (PTR+1)'($urandom_range(0, 15));
            for (int c = 0; c < 64; c++) begin
                int  r  = int'($urandom_range(0, 99));
                int  r2 = int'($urandom_range(0, 99));
                logic wr = (mode == 0) ? (r < 80) : (mode == 1) ? (r < 20) : (r < 50);
                logic rd = (mode == 0) ? (r2 < 20) : (mode == 1) ? (r2 < 80) : (r2 < 50);
                cycle(wr, rd, WORD_SIZE'($urandom), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter WORD_SIZE, default 10, data word width in bits (>=1).
REQ-002 Parameter MEM_SIZE, default 8, storage depth in words (power of two, >=2).
REQ-003 Parameter PTR, default 3, pointer width; SHALL equal log2(MEM_SIZE).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fifo_wr  input  1  write request.
REQ-007 fifo_rd  input  1  read request (in FWFT mode: pop of head word).
REQ-008 fifo_data_in  input  WORD_SIZE  write data.
REQ-009 full_threshold  input  PTR+1  almost-full level, in words.
REQ-010 empty_threshold  input  PTR+1  almost-empty level, in words.
REQ-011 fifo_data_out  output  WORD_SIZE  read data.
REQ-012 fifo_full / fifo_empty  output  1 each  occupancy == MEM_SIZE / occupancy == 0.
REQ-013 almost_full / almost_empty  output  1 each  threshold flags.
REQ-014 fifo_count  output  PTR+1  current occupancy, 0..MEM_SIZE.
REQ-015 error  output  1  sticky overflow/underflow indicator.

Function
REQ-016 Write accepted at a rising edge iff fifo_wr=1 and (fifo_full=0, or fifo_full=1 and a read is accepted in the same cycle); word stored at wr_ptr, wr_ptr increments modulo MEM_SIZE.
REQ-017 Read accepted iff fifo_rd=1 and fifo_empty=0; rd_ptr increments modulo MEM_SIZE.
REQ-018 Read with fifo_empty=1 is ignored (no pointer change); a write in that same cycle is still accepted.
REQ-019 fifo_count: +1 on write only, -1 on read only, unchanged when both or neither are accepted; never exceeds MEM_SIZE or goes below 0.
REQ-020 Flags combinational from fifo_count: almost_full = (fifo_count >= full_threshold); almost_empty = (fifo_count <= empty_threshold); full/empty per REQ-012.
REQ-021 Threshold compare unsigned, PTR+1 bits; threshold 0 makes almost_full always 1; threshold >= MEM_SIZE makes almost_empty always 1.
REQ-022 error set at the edge of an overflow (fifo_wr=1, full, no accepted read) or underflow (fifo_rd=1, empty); rejected write data discarded; error stays 1 until reset.
REQ-023 Standard mode: on an accepted read, fifo_data_out loads the head word at that edge (1-cycle latency); otherwise it holds its value.
REQ-024 Pointer wrap: after MEM_SIZE writes, wr_ptr returns to 0 and data order remains strict FIFO across wrap.

Reset
REQ-025 reset=0 asynchronously clears wr_ptr, rd_ptr, fifo_count, error and fifo_data_out to 0; fifo_empty=1, fifo_full=0 while asserted.
REQ-026 Memory array is not reset; contents are unobservable until rewritten.
REQ-027 Reset asserted mid-operation discards all stored words; first accepted write after release lands at address 0.
REQ-028 Requests sampled while reset=0 have no effect.

Configuration
REQ-029 Macro FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-030 With FIFO_FWFT_EN defined: fifo_data_out combinationally presents mem[rd_ptr] when fifo_empty=0 and 0 when empty; fifo_rd pops the head, next word visible in the following cycle; flags, count and error unchanged.
REQ-031 Without FIFO_FWFT_EN: standard registered-read behaviour per REQ-023.

Verification
REQ-032 Reset, then 8 writes 0x001..0x008 -> fifo_full=1, fifo_count=8, almost_full=1 (full_threshold=6) from the 6th write, error=0.
REQ-033 Full FIFO, fifo_wr=1 with 0x3FF, fifo_rd=0 -> error=1, count stays 8, subsequent reads return 0x001..0x008 in order (0x3FF never appears).
REQ-034 Empty FIFO, fifo_rd=1 alone -> error=1, count 0, fifo_data_out unchanged; error remains 1 until reset=0.
REQ-035 Full FIFO, fifo_wr=1 and fifo_rd=1 for 12 cycles with incrementing data -> count stays 8, no error, output order correct across pointer wrap.
REQ-036 count=3, empty_threshold=1: two reads -> almost_empty rises when count reaches 1; reset asserted mid-stream -> count 0, fifo_empty=1, fifo_data_out=0 immediately.
REQ-037 Repeat REQ-032/035 with FIFO_FWFT_EN: 0x001 appears on fifo_data_out one cycle after the first write, without any read.
